pc_sequencer: RTL and testbench

- Fetch-side consumer of the branch predictor's IF, ID and EXE outputs. It owns the PC register and the IF→ID→EXE PC/valid pipeline.
- Each cycle it selects the next fetch address by priority: EXE correction, ID unsaved jump, IF prediction, sequential.
- It marks squashed wrong-path slots invalid, so downstream stages and the predictor see bubbles.
- It sits between instruction memory and the predictor and drives that block's if_PC/id_PC/exe_PC inputs.

---
 rtl/pc_sequencer_pkg.sv | 25 ++
 rtl/pc_next_mux.sv | 49 ++++
 rtl/pc_sequencer.sv | 163 ++++++++++++++++
 tb/tb_pc_sequencer.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_sequencer_pkg.sv
// Shared encodings for the fetch PC sequencer: FSM states, EXE correction codes, next-PC sources.
// Pure definitions; no latency or stall behaviour of its own.
package pc_sequencer_pkg;

    localparam int PC_W_DEF = 11;

    localparam logic [1:0] ST_BOOT   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_SQUASH = 2'd2;

    localparam logic [1:0] CORR_CNI = 2'b10;
    localparam logic [1:0] CORR_PBT = 2'b11;

    typedef enum logic [1:0] {
        SRC_SEQ = 2'd0,
        SRC_IF  = 2'd1,
        SRC_ID  = 2'd2,
        SRC_EXE = 2'd3
    } pc_src_e;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/pc_next_mux.sv
// Combinational next-fetch-address priority select (EXE > ID > IF > sequential) plus redirect flag.
// Zero latency; with en_i low it reports no redirect so a stalled pipe never looks redirected.
module pc_next_mux
    import pc_sequencer_pkg::*;
#(
    parameter int PC_W = PC_W_DEF
) (
    input  logic            en_i,
    input  logic [PC_W-1:0] if_pc_i,
    input  logic            if_valid_i,
    input  logic            if_prediction_i,
    input  logic [PC_W-1:0] if_pbt_i,
    input  logic            id_valid_i,
    input  logic            id_is_jump_i,
    input  logic            id_jump_in_bht_i,
    input  logic [PC_W-1:0] id_branchtarget_i,
    input  logic            exe_valid_i,
    input  logic [1:0]      exe_correction_i,
    input  logic [PC_W-1:0] exe_pbt_i,
    input  logic [PC_W-1:0] exe_cni_i,
    output logic [PC_W-1:0] next_pc_o,
    output pc_src_e         src_o,
    output logic            redirect_o
);

    localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

    always_comb begin
        src_o     = SRC_SEQ;
        next_pc_o = if_pc_i + PC_ONE;
        // A bubble in EXE or ID must never steer fetch, hence the valid qualifiers.
        if (exe_valid_i && (exe_correction_i == CORR_PBT)) begin
            src_o     = SRC_EXE;
            next_pc_o = exe_pbt_i;
        end else if (exe_valid_i && (exe_correction_i == CORR_CNI)) begin
            src_o     = SRC_EXE;
            next_pc_o = exe_cni_i;
        end else if (id_is_jump_i && id_valid_i && !id_jump_in_bht_i) begin
            src_o     = SRC_ID;
            next_pc_o = id_branchtarget_i;
        end else if (if_prediction_i && if_valid_i) begin
            src_o     = SRC_IF;
            next_pc_o = if_pbt_i;
        end
    end

    assign redirect_o = en_i && (src_o != SRC_SEQ);

endmodule

// File: rtl/pc_sequencer.sv
// Owns the fetch PC and the IF->ID->EXE PC/valid pipe; one-cycle PC update, squashes wrong-path slots.
// en low freezes every register; optional saturating event counters under PC_SEQ_PERF_CNT_EN.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int              PC_W     = PC_W_DEF,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            CLK,
    input  logic            nrst,
    input  logic            en,
    input  logic            if_prediction,
    input  logic [PC_W-1:0] if_PBT,
    input  logic            id_is_jump,
    input  logic            id_jump_in_bht,
    input  logic [PC_W-1:0] id_branchtarget,
    input  logic [1:0]      exe_correction,
    input  logic [PC_W-1:0] exe_PBT,
    input  logic [PC_W-1:0] exe_CNI,
    output logic [PC_W-1:0] if_PC,
    output logic [PC_W-1:0] id_PC,
    output logic [PC_W-1:0] exe_PC,
    output logic            if_valid,
    output logic            id_valid,
    output logic            exe_valid,
    output logic            redirect,
    output logic [1:0]      state
`ifdef PC_SEQ_PERF_CNT_EN
    ,
    output logic [15:0]     perf_mispredict,
    output logic [15:0]     perf_jump_redirect,
    output logic [15:0]     perf_pred_taken
`endif
);

    logic [PC_W-1:0] if_pc_q, if_pc_d;
    logic [PC_W-1:0] id_pc_q, id_pc_d;
    logic [PC_W-1:0] exe_pc_q, exe_pc_d;
    logic            if_valid_q, if_valid_d;
    logic            id_valid_q, id_valid_d;
    logic            exe_valid_q, exe_valid_d;
    logic [1:0]      state_q, state_d;

    logic [PC_W-1:0] mux_next_pc;
    pc_src_e         mux_src;
    logic            mux_redirect;

    pc_next_mux #(
        .PC_W (PC_W)
    ) u_next_mux (
        .en_i              (en),
        .if_pc_i           (if_pc_q),
        .if_valid_i        (if_valid_q),
        .if_prediction_i   (if_prediction),
        .if_pbt_i          (if_PBT),
        .id_valid_i        (id_valid_q),
        .id_is_jump_i      (id_is_jump),
        .id_jump_in_bht_i  (id_jump_in_bht),
        .id_branchtarget_i (id_branchtarget),
        .exe_valid_i       (exe_valid_q),
        .exe_correction_i  (exe_correction),
        .exe_pbt_i         (exe_PBT),
        .exe_cni_i         (exe_CNI),
        .next_pc_o         (mux_next_pc),
        .src_o             (mux_src),
        .redirect_o        (mux_redirect)
    );

    always_comb begin
        if_pc_d     = if_pc_q;
        id_pc_d     = id_pc_q;
        exe_pc_d    = exe_pc_q;
        if_valid_d  = if_valid_q;
        id_valid_d  = id_valid_q;
        exe_valid_d = exe_valid_q;
        state_d     = state_q;
        if (en) begin
            id_pc_d     = if_pc_q;
            exe_pc_d    = id_pc_q;
            id_valid_d  = if_valid_q;
            exe_valid_d = id_valid_q;
            if_valid_d  = 1'b1;
            if_pc_d     = mux_next_pc;
            state_d     = ST_RUN;
            if (state_q == ST_BOOT) begin
                if_pc_d = RESET_PC;
            end else if (mux_src == SRC_EXE) begin
                // Both younger slots were fetched down the wrong path.
                id_valid_d  = 1'b0;
                exe_valid_d = 1'b0;
                state_d     = ST_SQUASH;
            end else if (mux_src == SRC_ID) begin
                id_valid_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge CLK or negedge nrst) begin
        if (!nrst) begin
            if_pc_q     <= RESET_PC;
            id_pc_q     <= '0;
            exe_pc_q    <= '0;
            if_valid_q  <= 1'b0;
            id_valid_q  <= 1'b0;
            exe_valid_q <= 1'b0;
            state_q     <= ST_BOOT;
        end else begin
            if_pc_q     <= if_pc_d;
            id_pc_q     <= id_pc_d;
            exe_pc_q    <= exe_pc_d;
            if_valid_q  <= if_valid_d;
            id_valid_q  <= id_valid_d;
            exe_valid_q <= exe_valid_d;
            state_q     <= state_d;
        end
    end

    assign if_PC     = if_pc_q;
    assign id_PC     = id_pc_q;
    assign exe_PC    = exe_pc_q;
    assign if_valid  = if_valid_q;
    assign id_valid  = id_valid_q;
    assign exe_valid = exe_valid_q;
    assign redirect  = mux_redirect;
    assign state     = state_q;

`ifdef PC_SEQ_PERF_CNT_EN
    logic [15:0] perf_mis_q, perf_mis_d;
    logic [15:0] perf_jmp_q, perf_jmp_d;
    logic [15:0] perf_prd_q, perf_prd_d;

    always_comb begin
        perf_mis_d = perf_mis_q;
        perf_jmp_d = perf_jmp_q;
        perf_prd_d = perf_prd_q;
        if (en) begin
            case (mux_src)
                SRC_EXE: perf_mis_d = sat_inc16(perf_mis_q);
                SRC_ID:  perf_jmp_d = sat_inc16(perf_jmp_q);
                SRC_IF:  perf_prd_d = sat_inc16(perf_prd_q);
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge nrst) begin
        if (!nrst) begin
            perf_mis_q <= '0;
            perf_jmp_q <= '0;
            perf_prd_q <= '0;
        end else begin
            perf_mis_q <= perf_mis_d;
            perf_jmp_q <= perf_jmp_d;
            perf_prd_q <= perf_prd_d;
        end
    end

    assign perf_mispredict    = perf_mis_q;
    assign perf_jump_redirect = perf_jmp_q;
    assign perf_pred_taken    = perf_prd_q;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: directed walk through the key scenarios, then randomized traffic.
`timescale 1ns/1ps
module tb_pc_sequencer;

    localparam int          W   = 11;
    localparam logic [10:0] RPC = 11'h010;

    logic          CLK = 1'b0;
    logic          nrst = 1'b0;
    logic          en = 1'b0;
    logic          if_prediction = 1'b0;
    logic [W-1:0]  if_PBT = '0;
    logic          id_is_jump = 1'b0;
    logic          id_jump_in_bht = 1'b0;
    logic [W-1:0]  id_branchtarget = '0;
    logic [1:0]    exe_correction = 2'b00;
    logic [W-1:0]  exe_PBT = '0;
    logic [W-1:0]  exe_CNI = '0;
    logic [W-1:0]  if_PC, id_PC, exe_PC;
    logic          if_valid, id_valid, exe_valid, redirect;
    logic [1:0]    state;
`ifdef PC_SEQ_PERF_CNT_EN
    logic [15:0]   perf_mispredict, perf_jump_redirect, perf_pred_taken;
`endif

    pc_sequencer #(.PC_W(W), .RESET_PC(RPC)) dut (
        .CLK(CLK), .nrst(nrst), .en(en),
        .if_prediction(if_prediction), .if_PBT(if_PBT),
        .id_is_jump(id_is_jump), .id_jump_in_bht(id_jump_in_bht), .id_branchtarget(id_branchtarget),
        .exe_correction(exe_correction), .exe_PBT(exe_PBT), .exe_CNI(exe_CNI),
        .if_PC(if_PC), .id_PC(id_PC), .exe_PC(exe_PC),
        .if_valid(if_valid), .id_valid(id_valid), .exe_valid(exe_valid),
        .redirect(redirect), .state(state)
`ifdef PC_SEQ_PERF_CNT_EN
        , .perf_mispredict(perf_mispredict), .perf_jump_redirect(perf_jump_redirect),
        .perf_pred_taken(perf_pred_taken)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [10:0] ifpc, idpc, expc;
        logic        ifv, idv, exv;
        logic [1:0]  st;
        int          pm, pj, pp;
    } exp_t;

    exp_t q_reg[$];
    logic q_comb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: slot PCs/valids, phase 0=boot 1=run 2=squash, event counts.
    logic [10:0] m_if, m_id, m_exe;
    logic        m_ifv, m_idv, m_exv;
    int          m_phase, m_pm, m_pj, m_pp;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic model_reset();
        m_if = RPC; m_id = '0; m_exe = '0;
        m_ifv = 0; m_idv = 0; m_exv = 0;
        m_phase = 0; m_pm = 0; m_pj = 0; m_pp = 0;
    endtask

    // Applies one cycle of inputs, predicts the DUT response, and advances to 2ns after the edge.
    task automatic step(input bit e, input bit pr, input logic [10:0] pbt,
                        input bit jmp, input bit inbht, input logic [10:0] tgt,
                        input logic [1:0] corr, input logic [10:0] xp, input logic [10:0] xc);
        bit take_exe, take_id, take_if;
        logic [10:0] nxt;
        exp_t ex;
        en = e; if_prediction = pr; if_PBT = pbt;
        id_is_jump = jmp; id_jump_in_bht = inbht; id_branchtarget = tgt;
        exe_correction = corr; exe_PBT = xp; exe_CNI = xc;
        take_exe = 0; take_id = 0; take_if = 0;
        nxt = m_if + 11'd1;
        if (e && m_phase != 0) begin
            take_exe = m_exv && corr[1];
            take_id  = !take_exe && jmp && m_idv && !inbht;
            take_if  = !take_exe && !take_id && pr && m_ifv;
            if (take_exe)     nxt = corr[0] ? xp : xc;
            else if (take_id) nxt = tgt;
            else if (take_if) nxt = pbt;
        end
        q_comb.push_back(take_exe | take_id | take_if);
        if (e) begin
            if (m_phase == 0) nxt = RPC;
            m_exe = m_id;
            m_id  = m_if;
            m_exv = take_exe ? 1'b0 : m_idv;
            m_idv = (take_exe || take_id) ? 1'b0 : m_ifv;
            m_ifv = 1'b1;
            m_if  = nxt;
            m_phase = take_exe ? 2 : 1;
            if (take_exe && m_pm < 65535) m_pm++;
            if (take_id  && m_pj < 65535) m_pj++;
            if (take_if  && m_pp < 65535) m_pp++;
        end
        ex.ifpc = m_if; ex.idpc = m_id; ex.expc = m_exe;
        ex.ifv = m_ifv; ex.idv = m_idv; ex.exv = m_exv;
        ex.st = 2'(m_phase); ex.pm = m_pm; ex.pj = m_pj; ex.pp = m_pp;
        q_reg.push_back(ex);
        @(posedge CLK);
        #2;
    endtask

    task automatic step_seq(input bit e);
        step(e, 0, '0, 0, 0, '0, 2'b00, '0, '0);
    endtask

    // Called 2ns after an edge, when both scoreboard queues have drained.
    task automatic do_reset(input int hold);
        nrst = 1'b0;
        #1;
        chk("rst_if_PC", if_PC, RPC);
        chk("rst_id_PC", id_PC, 0);
        chk("rst_exe_PC", exe_PC, 0);
        chk("rst_valids", {if_valid, id_valid, exe_valid}, 0);
        chk("rst_state", state, 0);
        chk("rst_redirect", redirect, 0);
        repeat (hold) @(posedge CLK);
        #2;
        nrst = 1'b1;
        model_reset();
    endtask

    initial begin : mon_reg
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (q_reg.size() > 0) begin
                e = q_reg.pop_front();
                chk("if_PC", if_PC, e.ifpc);
                chk("id_PC", id_PC, e.idpc);
                chk("exe_PC", exe_PC, e.expc);
                chk("if_valid", if_valid, e.ifv);
                chk("id_valid", id_valid, e.idv);
                chk("exe_valid", exe_valid, e.exv);
                chk("state", state, e.st);
`ifdef PC_SEQ_PERF_CNT_EN
                chk("perf_mispredict", perf_mispredict, e.pm);
                chk("perf_jump_redirect", perf_jump_redirect, e.pj);
                chk("perf_pred_taken", perf_pred_taken, e.pp);
`endif
            end
        end
    end

    initial begin : mon_comb
        logic r;
        forever begin
            @(negedge CLK);
            if (q_comb.size() > 0) begin
                r = q_comb.pop_front();
                chk("redirect", redirect, r);
            end
        end
    end

    initial begin : stim
        model_reset();
        @(posedge CLK);
        #2;
        do_reset(2);

        // Boot then sequential fetch from RESET_PC.
        step_seq(1);
        chk("boot_to_run", state, 1);
        chk("first_if_PC", if_PC, 11'h010);
        step_seq(1);
        chk("seq_if_PC_011", if_PC, 11'h011);
        chk("exe_valid_early", exe_valid, 0);
        step_seq(1);
        chk("seq_if_PC_012", if_PC, 11'h012);
        chk("exe_valid_3rd_run", exe_valid, 1);

        // IF prediction, then unsaved ID jump.
        step(1, 1, 11'h040, 0, 0, '0, 2'b00, '0, '0);
        chk("pred_if_PC", if_PC, 11'h040);
        chk("pred_id_PC", id_PC, 11'h012);
        step(1, 0, '0, 1, 0, 11'h080, 2'b00, '0, '0);
        chk("jump_if_PC", if_PC, 11'h080);
        chk("jump_id_valid", id_valid, 0);
        chk("jump_exe_valid", exe_valid, 1);
        step_seq(1);
        step_seq(1);

        // EXE correction overriding a same-cycle ID jump.
        step(1, 1, 11'h555, 1, 0, 11'h100, 2'b10, 11'h3AA, 11'h021);
        chk("corr_if_PC", if_PC, 11'h021);
        chk("corr_valids", {id_valid, exe_valid}, 0);
        chk("corr_state", state, 2);
        // Correction on an invalid EXE slot is ignored.
        step(1, 0, '0, 0, 0, '0, 2'b11, 11'h300, '0);
        chk("ignored_corr_if_PC", if_PC, 11'h022);
        chk("squash_back_to_run", state, 1);
        step_seq(1);

        // Stall with a correction pending, then release.
        repeat (3) begin
            step(0, 0, '0, 0, 0, '0, 2'b11, 11'h155, '0);
            chk("stall_if_PC", if_PC, 11'h023);
            chk("stall_exe_valid", exe_valid, 1);
        end
        step(1, 0, '0, 0, 0, '0, 2'b11, 11'h155, '0);
        chk("stall_release_if_PC", if_PC, 11'h155);
        chk("stall_release_state", state, 2);

        // Wrap from the top of the address space.
        step(1, 1, 11'h7FF, 0, 0, '0, 2'b00, '0, '0);
        chk("pre_wrap_if_PC", if_PC, 11'h7FF);
        step_seq(1);
        chk("wrap_if_PC", if_PC, 11'h000);

        // Reset asserted while in SQUASH.
        step(1, 0, '0, 0, 0, '0, 2'b10, '0, 11'h5A5);
        chk("pre_reset_state", state, 2);
        do_reset(1);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 399) == 0) begin
                do_reset($urandom_range(1, 3));
            end else begin
                step($urandom_range(0, 7) != 0,
                     $urandom_range(0, 2) == 0, 11'($urandom),
                     $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, 11'($urandom),
                     2'($urandom_range(0, 3)), 11'($urandom), 11'($urandom));
            end
        end

        step_seq(0);
        @(posedge CLK);
        #2;
        chk("scoreboard_drained", q_reg.size() + q_comb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
